// File: rtl/cbm2_pkg.sv
// Shared types and constants for the CBM-II 6509 segment logic.
package cbm2_pkg;

  typedef logic [3:0] seg_t;

  localparam logic [7:0] OPC_LDA_IZY = 8'hB1;
  localparam logic [7:0] OPC_STA_IZY = 8'h91;
  localparam logic [2:0] CYC_MAX     = 3'd7;

  // Tracker state, exported so checkers can observe cycle position.
  typedef struct packed {
    logic [2:0] cycCnt;
    logic       indOp;
  } trkDbg_t;

  function automatic logic isIndOpcode(input logic [7:0] opc,
                                       input logic [7:0] opcLda,
                                       input logic [7:0] opcSta);
    return (opc == opcLda) || (opc == opcSta);
  endfunction

endpackage

// File: rtl/cbm2_segment_ctl_if.sv
// CPU-side bus between the T65 core, the bus decoder and the segment logic.
interface cbm2_segment_ctl_if;
  import cbm2_pkg::*;

  // cpu_en is the only qualifier: inputs are sampled and state commits on
  // clocks where it is high; there is no backpressure, and the outputs are
  // combinational and valid for the whole CPU cycle.
  logic        cpu_en;
  logic        cpuSync;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDo;
  logic        cpuWe;
  logic [7:0]  cpuDi;
  logic [7:0]  cpuSeg;
  logic        seg_cs;
  logic [7:0]  seg_do;
  trkDbg_t     dbg;

  modport master (
    output cpu_en, cpuSync, cpuAddr, cpuDo, cpuWe, cpuDi,
    input  cpuSeg, seg_cs, seg_do, dbg
  );

  modport slave (
    input  cpu_en, cpuSync, cpuAddr, cpuDo, cpuWe, cpuDi,
    output cpuSeg, seg_cs, seg_do, dbg
  );

endinterface

// File: rtl/cbm2_ind_tracker.sv
// Counts T65 cycles since the last opcode fetch and flags the data cycles
// of LDA/STA (zp),Y that must be steered to the indirection segment.
module cbm2_ind_tracker
  import cbm2_pkg::*;
#(
  parameter logic [7:0] OPC_LDA = OPC_LDA_IZY,
  parameter logic [7:0] OPC_STA = OPC_STA_IZY
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cpu_en,
  input  logic       cpuSync,
  input  logic [7:0] cpuDi,
  output logic       useInd,
  output trkDbg_t    dbg
);

  logic [2:0] cycCnt, cycCntNxt;
  logic       indOp, indOpNxt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cycCnt <= 3'd0;
      indOp  <= 1'b0;
    end else begin
      cycCnt <= cycCntNxt;
      indOp  <= indOpNxt;
    end
  end

  // An opcode fetch restarts the count ahead of the saturation rule.
  always_comb begin
    cycCntNxt = cycCnt;
    indOpNxt  = indOp;
    if (cpu_en) begin
      if (cpuSync) begin
        cycCntNxt = 3'd1;
        indOpNxt  = isIndOpcode(cpuDi, OPC_LDA, OPC_STA);
      end else if (cycCnt != CYC_MAX) begin
        cycCntNxt = cycCnt + 3'd1;
      end
    end
  end

  // Cycle 5 of a non-crossing LDA is the next opcode fetch, which cpuSync excludes.
  assign useInd = indOp && !cpuSync && ((cycCnt == 3'd4) || (cycCnt == 3'd5));

  assign dbg.cycCnt = cycCnt;
  assign dbg.indOp  = indOp;

endmodule

// File: rtl/cbm2_segment_ctl.sv
// 6509 execution/indirection segment registers at $0000/$0001 and the
// segment mux feeding the CBM-II bus decoder.
module cbm2_segment_ctl
  import cbm2_pkg::*;
#(
  parameter seg_t       RESET_SEG   = 4'hF,
  parameter logic [7:0] OPC_LDA_IZY = 8'hB1,
  parameter logic [7:0] OPC_STA_IZY = 8'h91
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  cbm2_segment_ctl_if.slave  bus
);

  seg_t execReg;
  seg_t indReg;
  logic useInd;
  logic regWr;
  logic [3:0] unusedDoHi;

  assign unusedDoHi = bus.cpuDo[7:4];

  assign bus.seg_cs = (bus.cpuAddr[15:1] == 15'd0);
  assign bus.seg_do = {4'h0, bus.cpuAddr[0] ? indReg : execReg};
  assign regWr      = bus.cpu_en & bus.cpuWe & bus.seg_cs;

  // Writes land at the end of the cycle, so the current access keeps the old value.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      execReg <= RESET_SEG;
      indReg  <= RESET_SEG;
    end else if (regWr) begin
      if (bus.cpuAddr[0]) begin
        indReg <= bus.cpuDo[3:0];
      end else begin
        execReg <= bus.cpuDo[3:0];
      end
    end
  end

  cbm2_ind_tracker #(
    .OPC_LDA (OPC_LDA_IZY),
    .OPC_STA (OPC_STA_IZY)
  ) u_tracker (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .cpu_en  (bus.cpu_en),
    .cpuSync (bus.cpuSync),
    .cpuDi   (bus.cpuDi),
    .useInd  (useInd),
    .dbg     (bus.dbg)
  );

  assign bus.cpuSeg = {4'h0, useInd ? indReg : execReg};

endmodule
